// File: rtl/mul_issue_arbiter_if.sv
// Bundle between reservation stations, the shared multiplier and the writeback arbiter.
// The arbiter takes the slave view; the surrounding pipeline (or a bench) takes the master view.
interface mul_issue_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*2-1:0]      req_op;
    logic [NUM_REQ*TAG_W-1:0]  req_tag;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      fu_start;
    logic [DATA_W-1:0]         fu_a;
    logic [DATA_W-1:0]         fu_b;
    logic [1:0]                fu_op;
    logic [DATA_W-1:0]         fu_result;

    logic                      resp_valid;
    logic                      resp_ready;
    logic [DATA_W-1:0]         resp_data;
    logic [TAG_W-1:0]          resp_tag;
    logic [SRC_W-1:0]          resp_src;

    logic                      flush;
    logic                      busy;

    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag,
        input  fu_result, resp_ready, flush,
        output req_ready, fu_start, fu_a, fu_b, fu_op,
        output resp_valid, resp_data, resp_tag, resp_src, busy
    );

    modport master (
        output req_valid, req_a, req_b, req_op, req_tag,
        output fu_result, resp_ready, flush,
        input  req_ready, fu_start, fu_a, fu_b, fu_op,
        input  resp_valid, resp_data, resp_tag, resp_src, busy
    );
endinterface

// File: rtl/mul_issue_arbiter.sv
// Round-robin issue of NUM_REQ requesters onto one fixed-latency multiplier; result held on a
// valid/ready port. Grant to resp_valid is FU_LATENCY+1 cycles; RESP holds while resp_ready is low.
module mul_issue_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 32,
    parameter int TAG_W      = 6,
    parameter int FU_LATENCY = 3
) (
    input  logic               i_clk,
    input  logic               i_rst,
    mul_issue_arbiter_if.slave io_bus
);
    localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(FU_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [SRC_W-1:0]     r_rr_ptr;
    logic [SRC_W-1:0]     r_src;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_fu_start;
    logic [DATA_W-1:0]    r_a;
    logic [DATA_W-1:0]    r_b;
    logic [1:0]           r_op;
    logic [TAG_W-1:0]     r_tag;
    logic [DATA_W-1:0]    r_resp_data;

    logic [2*NUM_REQ-1:0] w_dbl;
    logic [NUM_REQ-1:0]   w_rot;
    logic [NUM_REQ-1:0]   w_ready;
    logic                 w_any;
    logic                 w_grant;
    logic                 w_last;
    logic [SRC_W-1:0]     w_off;
    logic [SRC_W:0]       w_sum;
    logic [SRC_W-1:0]     w_winner;
    logic [SRC_W-1:0]     w_ptr_nxt;
    logic [DATA_W-1:0]    w_sel_a;
    logic [DATA_W-1:0]    w_sel_b;
    logic [1:0]           w_sel_op;
    logic [TAG_W-1:0]     w_sel_tag;

    // Rotate the request vector so bit 0 is the requester at r_rr_ptr; the lowest set bit
    // of the rotated vector is then the round-robin winner's offset from the pointer.
    always_comb begin
        w_dbl = {io_bus.req_valid, io_bus.req_valid} >> r_rr_ptr;
        w_rot = w_dbl[NUM_REQ-1:0];
        w_any = |w_rot;
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = SRC_W'(k);
            end
        end
        w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
        if (w_sum >= (SRC_W + 1)'(NUM_REQ)) begin
            w_sum = w_sum - (SRC_W + 1)'(NUM_REQ);
        end
        w_winner = w_sum[SRC_W-1:0];
    end

    assign w_ptr_nxt = (w_winner == SRC_W'(NUM_REQ - 1)) ? '0 : w_winner + SRC_W'(1);
    assign w_grant   = (r_state == ST_IDLE) && w_any && !io_bus.flush && !i_rst;
    assign w_last    = (r_state == ST_EXEC) && (r_cnt == CNT_W'(1));

    always_comb begin
        w_ready   = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_op  = '0;
        w_sel_tag = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_winner == SRC_W'(k)) begin
                w_sel_a   = io_bus.req_a[k*DATA_W +: DATA_W];
                w_sel_b   = io_bus.req_b[k*DATA_W +: DATA_W];
                w_sel_op  = io_bus.req_op[k*2 +: 2];
                w_sel_tag = io_bus.req_tag[k*TAG_W +: TAG_W];
                w_ready[k] = w_grant;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_grant) w_state_nxt = ST_EXEC;
            ST_EXEC: if (w_last) w_state_nxt = ST_RESP;
            ST_RESP: if (io_bus.resp_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (io_bus.flush) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // Flush drops the in-flight op but leaves the pointer alone, so the next grant
    // naturally goes to the requester after the squashed winner.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr    <= '0;
            r_src       <= '0;
            r_cnt       <= '0;
            r_fu_start  <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_tag       <= '0;
            r_resp_data <= '0;
        end else if (io_bus.flush) begin
            r_fu_start <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_fu_start <= w_grant;
            if (w_grant) begin
                r_a      <= w_sel_a;
                r_b      <= w_sel_b;
                r_op     <= w_sel_op;
                r_tag    <= w_sel_tag;
                r_src    <= w_winner;
                r_rr_ptr <= w_ptr_nxt;
                r_cnt    <= CNT_W'(FU_LATENCY);
            end else if (r_state == ST_EXEC) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if (w_last) begin
                    r_resp_data <= io_bus.fu_result;
                end
            end
        end
    end

    assign io_bus.req_ready  = w_ready;
    assign io_bus.fu_start   = r_fu_start;
    assign io_bus.fu_a       = r_a;
    assign io_bus.fu_b       = r_b;
    assign io_bus.fu_op      = r_op;
    assign io_bus.resp_valid = (r_state == ST_RESP);
    assign io_bus.resp_data  = r_resp_data;
    assign io_bus.resp_tag   = r_tag;
    assign io_bus.resp_src   = r_src;
    assign io_bus.busy       = (r_state != ST_IDLE);

endmodule

// File: doc/mul_issue_arbiter.md
# mul_issue_arbiter

Round-robin arbiter and sequencer that shares one fixed-latency, pipelined-input multiply functional unit among `NUM_REQ` reservation-station requesters. It grants one requester per operation, latches operands and destination tag, drives the FU start/operand lines, counts the FU latency, captures the result, and holds it on a valid/ready port toward the CDB/writeback arbiter. It sits between the reservation stations and the multiplier, beside the single-cycle ALU path.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `DATA_W`, 32: operand/result width.
- `TAG_W`, 6: physical destination register tag width.
- `FU_LATENCY`, 3: cycles from `fu_start` to valid `fu_result` (≥1).
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in NUM_REQ: requester i has a ready multiply.
- `req_a`, `req_b` in NUM_REQ*DATA_W: operands, slice i = bits [i*DATA_W +: DATA_W].
- `req_op` in NUM_REQ*2: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- `req_tag` in NUM_REQ*TAG_W: destination tag.
- `req_ready` out NUM_REQ: one-hot grant; requester i dequeues when `req_valid[i] & req_ready[i]`.
- `fu_start` out 1: one-cycle start pulse to FU.
- `fu_a`, `fu_b` out DATA_W; `fu_op` out 2: latched operands/op, stable for whole EXEC.
- `fu_result` in DATA_W: FU output, valid in the last EXEC cycle.
- `resp_valid` out 1; `resp_ready` in 1: result handshake.
- `resp_data` out DATA_W; `resp_tag` out TAG_W; `resp_src` out clog2(NUM_REQ): result, tag, granted requester index.
- `flush` in 1: squash (branch mispredict).
- `busy` out 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any `req_valid` and not `flush`, select winner by round-robin starting at `rr_ptr`; `req_ready[winner]=1` (combinational, only in IDLE); latch a/b/op/tag/winner; `rr_ptr <= winner+1` (wraps NUM_REQ-1→0); go EXEC with `cnt <= FU_LATENCY`.
- EXEC: `fu_start=1` only in first EXEC cycle; `cnt` decrements each cycle; in cycle with `cnt==1` capture `fu_result` into `resp_data`, go RESP.
- RESP: `resp_valid=1`, data/tag/src stable until `resp_ready`; on handshake go IDLE. No grant in RESP or EXEC (`req_ready` all 0).
- `flush` (any state, highest priority): next state IDLE, `resp_valid` low next cycle, in-flight op dropped, `rr_ptr` unchanged, `req_ready` all 0 in the flush cycle.
- Round-robin fairness: a continuously valid requester is granted within NUM_REQ grants.
- Operands passed through unmodified; no arithmetic beyond `cnt` and `rr_ptr` modulo wrap.

## Timing
- Reset: state IDLE, `rr_ptr=0`, `cnt=0`, `fu_start=0`, `fu_a/fu_b/fu_op=0`, `resp_valid=0`, `resp_data/resp_tag/resp_src=0`, `busy=0`, `req_ready=0`.
- Grant cycle G (IDLE); EXEC cycles G+1 .. G+FU_LATENCY; `fu_start` at G+1; `resp_valid` first high at G+FU_LATENCY+1.
- With `resp_ready` high on arrival: RESP lasts 1 cycle, IDLE at G+FU_LATENCY+2, next grant possible that cycle. Max throughput 1 op per FU_LATENCY+2 cycles.
- `resp_ready` low: RESP holds indefinitely, outputs unchanged.
- `rst` mid-operation: reset values next cycle, overrides `flush`.
- `rst` or `flush` in same cycle as `req_valid`: no grant.

## Test plan
- Reset: hold `rst` 2 cycles with `req_valid=4'b1111` -> all outputs at reset values, `req_ready=0`; first grant to requester 0 in first cycle after `rst` drops.
- Single op, FU_LATENCY=3: req 2 valid, a=7, b=6, tag=0x15, FU model returns a*b -> `req_ready=4'b0100` at G, `fu_start` at G+1 only, `resp_valid` at G+4 with data 42, tag 0x15, src 2.
- Round-robin: all four valid continuously, `resp_ready=1` -> grant order 0,1,2,3,0, grants spaced 5 cycles.
- Backpressure: `resp_ready=0` for 6 cycles in RESP -> `resp_valid` and data stable, no grant; releases to IDLE the cycle after handshake.
- Flush in second EXEC cycle -> IDLE next cycle, no `resp_valid` for that op, next grant goes to requester after the flushed winner.
- Wrap/skip: `rr_ptr=3`, only req 1 valid -> req 1 granted, `rr_ptr` becomes 2.
